// File: rtl/fm_radio_pkg.sv
// Shared audio-path constants for the FM radio datapath.
// No logic; widths and depths only.
// Consumers import this to pick up default sample width and buffer depth.
package fm_radio_pkg;
    localparam int AUDIO_DATA_WIDTH = 32;
    localparam int AUDIO_FIFO_DEPTH = 16;
endpackage

// File: rtl/fm_fwft_fifo.sv
// Single-channel first-word-fall-through FIFO; head word visible on dout while not empty.
// Latency: a word written at edge N is on dout after edge N; full/empty decode the pointers combinationally.
// Backpressure: writes while full are dropped; reads while empty are ignored.
module fm_fwft_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  wr_en,
    output logic                  full,
    output logic [DATA_WIDTH-1:0] dout,
    input  logic                  rd_en,
    output logic                  empty
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW:0]           r_wr_ptr;
    logic [AW:0]           r_rd_ptr;
    logic                  w_push;
    logic                  w_pop;

    // Pointer MSB is the wrap bit: equal indices mean empty or full depending on it.
    assign empty  = (r_wr_ptr == r_rd_ptr);
    assign full   = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign w_push = wr_en & ~full;
    assign w_pop  = rd_en & ~empty;
    assign dout   = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
            if (w_pop)  r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end
endmodule

// File: rtl/fm_audio_out_buffer.sv
// Stereo output buffer: per-channel FWFT FIFOs presented downstream as matched left/right pairs.
// Latency: a pair is visible the cycle after its second sample is written (zero-cycle fall-through).
// Backpressure: per-channel full stalls producers; out_empty holds off the reader; misuse sets sticky errors.
module fm_audio_out_buffer
    import fm_radio_pkg::*;
#(
    parameter int DATA_WIDTH = AUDIO_DATA_WIDTH,
    parameter int FIFO_DEPTH = AUDIO_FIFO_DEPTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] left_din,
    input  logic                  left_wr_en,
    output logic                  left_full,
    input  logic [DATA_WIDTH-1:0] right_din,
    input  logic                  right_wr_en,
    output logic                  right_full,
    output logic [DATA_WIDTH-1:0] left_out,
    output logic [DATA_WIDTH-1:0] right_out,
    input  logic                  out_rd_en,
    output logic                  out_empty,
    output logic                  overflow_err,
    output logic                  underflow_err
);
    logic                  w_left_empty;
    logic                  w_right_empty;
    logic [DATA_WIDTH-1:0] w_left_dout;
    logic [DATA_WIDTH-1:0] w_right_dout;
    logic                  w_pop;
    logic                  r_overflow_err;
    logic                  r_underflow_err;

    // Both channels pop together, and only when each holds a sample.
    assign out_empty = w_left_empty | w_right_empty;
    assign w_pop     = out_rd_en & ~out_empty;

    fm_fwft_fifo #(
        .DATA_WIDTH(DATA_WIDTH),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_left_fifo (
        .clock(clock),
        .reset(reset),
        .din  (left_din),
        .wr_en(left_wr_en),
        .full (left_full),
        .dout (w_left_dout),
        .rd_en(w_pop),
        .empty(w_left_empty)
    );

    fm_fwft_fifo #(
        .DATA_WIDTH(DATA_WIDTH),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_right_fifo (
        .clock(clock),
        .reset(reset),
        .din  (right_din),
        .wr_en(right_wr_en),
        .full (right_full),
        .dout (w_right_dout),
        .rd_en(w_pop),
        .empty(w_right_empty)
    );

    // Mask so stale storage never leaks out while no complete pair exists.
    assign left_out  = out_empty ? '0 : w_left_dout;
    assign right_out = out_empty ? '0 : w_right_dout;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_overflow_err  <= 1'b0;
            r_underflow_err <= 1'b0;
        end else begin
            if ((left_wr_en & left_full) | (right_wr_en & right_full)) r_overflow_err <= 1'b1;
            if (out_rd_en & out_empty) r_underflow_err <= 1'b1;
        end
    end

    assign overflow_err  = r_overflow_err;
    assign underflow_err = r_underflow_err;
endmodule

// File: tb/tb_fm_audio_out_buffer.sv
// Directed bench for fm_audio_out_buffer with hand-computed expectations.
// Inputs change 1 ns after the rising edge; outputs are checked after that settling point.
module tb_fm_audio_out_buffer;
    logic        clock;
    logic        reset;
    logic [31:0] left_din;
    logic        left_wr_en;
    logic        left_full;
    logic [31:0] right_din;
    logic        right_wr_en;
    logic        right_full;
    logic [31:0] left_out;
    logic [31:0] right_out;
    logic        out_rd_en;
    logic        out_empty;
    logic        overflow_err;
    logic        underflow_err;

    int checks = 0;
    int errors = 0;

    fm_audio_out_buffer dut (
        .clock        (clock),
        .reset        (reset),
        .left_din     (left_din),
        .left_wr_en   (left_wr_en),
        .left_full    (left_full),
        .right_din    (right_din),
        .right_wr_en  (right_wr_en),
        .right_full   (right_full),
        .left_out     (left_out),
        .right_out    (right_out),
        .out_rd_en    (out_rd_en),
        .out_empty    (out_empty),
        .overflow_err (overflow_err),
        .underflow_err(underflow_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        left_wr_en  = 1'b0;
        right_wr_en = 1'b0;
        out_rd_en   = 1'b0;
    endtask

    task automatic push_pair(input logic [31:0] l, input logic [31:0] r);
        left_din    = l;
        right_din   = r;
        left_wr_en  = 1'b1;
        right_wr_en = 1'b1;
        tick();
        idle();
    endtask

    task automatic pop_pair();
        out_rd_en = 1'b1;
        tick();
        idle();
    endtask

    task automatic do_reset(input int cycles);
        idle();
        reset = 1'b1;
        repeat (cycles) tick();
        reset = 1'b0;
    endtask

    task automatic check_idle_state(input string tag);
        chk({tag, "_empty"}, 32'(out_empty), 32'd1);
        chk({tag, "_lfull"}, 32'(left_full), 32'd0);
        chk({tag, "_rfull"}, 32'(right_full), 32'd0);
        chk({tag, "_lout"}, left_out, 32'd0);
        chk({tag, "_rout"}, right_out, 32'd0);
        chk({tag, "_ovf"}, 32'(overflow_err), 32'd0);
        chk({tag, "_unf"}, 32'(underflow_err), 32'd0);
    endtask

    initial begin
        logic [31:0] v;
        left_din  = '0;
        right_din = '0;
        idle();

        // Reset
        do_reset(2);
        check_idle_state("reset");

        // Unpaired then paired
        left_din   = 32'h0000_1234;
        left_wr_en = 1'b1;
        tick();
        idle();
        chk("unpaired_empty0", 32'(out_empty), 32'd1);
        chk("unpaired_lout_masked", left_out, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("unpaired_empty_wait", 32'(out_empty), 32'd1);
        end
        right_din   = 32'hFFFF_EDCC;
        right_wr_en = 1'b1;
        tick();
        idle();
        chk("paired_empty", 32'(out_empty), 32'd0);
        chk("paired_lout", left_out, 32'h0000_1234);
        chk("paired_rout", right_out, 32'hFFFF_EDCC);
        pop_pair();
        chk("paired_pop_empty", 32'(out_empty), 32'd1);
        chk("paired_pop_unf", 32'(underflow_err), 32'd0);

        // Fill, overflow, drain; repeated so pointers wrap several times
        for (int rep = 0; rep < 4; rep++) begin
            for (int i = 0; i < 16; i++) begin
                chk("fill_not_full", 32'(left_full | right_full), 32'd0);
                push_pair(32'(i), 32'(i) ^ 32'hA5A5_0000);
            end
            chk("fill_lfull", 32'(left_full), 32'd1);
            chk("fill_rfull", 32'(right_full), 32'd1);
            push_pair(32'd99, 32'd99);
            chk("fill_ovf", 32'(overflow_err), 32'd1);
            chk("fill_still_full", 32'(left_full & right_full), 32'd1);
            for (int i = 0; i < 16; i++) begin
                chk("drain_empty", 32'(out_empty), 32'd0);
                chk("drain_lout", left_out, 32'(i));
                chk("drain_rout", right_out, 32'(i) ^ 32'hA5A5_0000);
                pop_pair();
            end
            chk("drain_done_empty", 32'(out_empty), 32'd1);
        end

        // Write while full with a simultaneous pop: write still dropped, pop happens
        do_reset(1);
        for (int i = 0; i < 16; i++) push_pair(32'(i + 200), 32'(i + 300));
        left_din    = 32'd99;
        right_din   = 32'd99;
        left_wr_en  = 1'b1;
        right_wr_en = 1'b1;
        out_rd_en   = 1'b1;
        tick();
        idle();
        chk("fullpop_ovf", 32'(overflow_err), 32'd1);
        chk("fullpop_not_full", 32'(left_full | right_full), 32'd0);
        for (int i = 1; i < 16; i++) begin
            chk("fullpop_lout", left_out, 32'(i + 200));
            chk("fullpop_rout", right_out, 32'(i + 300));
            pop_pair();
        end
        chk("fullpop_empty", 32'(out_empty), 32'd1);

        // Streaming: one pair preloaded, write+read every cycle
        do_reset(1);
        push_pair(32'd1000, 32'd5000);
        for (int k = 0; k < 100; k++) begin
            chk("stream_lout", left_out, 32'(1000 + k));
            chk("stream_rout", right_out, 32'(5000 + k));
            left_din    = 32'(1001 + k);
            right_din   = 32'(5001 + k);
            left_wr_en  = 1'b1;
            right_wr_en = 1'b1;
            out_rd_en   = 1'b1;
            tick();
            idle();
            chk("stream_empty", 32'(out_empty), 32'd0);
        end
        chk("stream_tail_l", left_out, 32'd1100);
        chk("stream_tail_r", right_out, 32'd5100);
        pop_pair();
        chk("stream_count1_empty", 32'(out_empty), 32'd1);
        chk("stream_unf", 32'(underflow_err), 32'd0);

        // Underflow
        out_rd_en = 1'b1;
        tick();
        idle();
        chk("unf_flag", 32'(underflow_err), 32'd1);
        chk("unf_empty", 32'(out_empty), 32'd1);
        push_pair(32'h0000_0055, 32'h0000_0066);
        chk("unf_after_lout", left_out, 32'h0000_0055);
        chk("unf_after_rout", right_out, 32'h0000_0066);
        pop_pair();
        chk("unf_after_empty", 32'(out_empty), 32'd1);

        // Push to empty with a same-cycle pop: pop ignored, word appears
        left_din    = 32'h0000_0A0A;
        right_din   = 32'h0000_0B0B;
        left_wr_en  = 1'b1;
        right_wr_en = 1'b1;
        out_rd_en   = 1'b1;
        tick();
        idle();
        chk("pushpop_empty", 32'(out_empty), 32'd0);
        chk("pushpop_lout", left_out, 32'h0000_0A0A);
        v = right_out;
        chk("pushpop_rout", v, 32'h0000_0B0B);

        // Reset mid-stream
        for (int i = 0; i < 5; i++) push_pair(32'(i + 40), 32'(i + 50));
        do_reset(1);
        check_idle_state("midreset");
        push_pair(32'd7, 32'd8);
        chk("midreset_lout", left_out, 32'd7);
        chk("midreset_rout", right_out, 32'd8);
        pop_pair();
        chk("midreset_empty", 32'(out_empty), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
